// File: rtl/data_mem_write_port_if.sv
// Commit-port and load-port bundle between the store buffer / load unit
// (master) and the data memory write port (slave).
interface data_mem_write_port_if #(
    parameter int WORD_SIZE_P = 16
);
    logic                   sb_mem_v_i;
    logic [WORD_SIZE_P-1:0] sb_mem_addr_i;
    logic [WORD_SIZE_P-1:0] sb_mem_data_i;
    logic                   mem_sb_full_o;
    logic                   ld_v_i;
    logic [WORD_SIZE_P-1:0] ld_addr_i;
    logic                   ld_ready_o;
    logic                   mem_ld_v_o;
    logic [WORD_SIZE_P-1:0] mem_ld_data_o;
    logic                   wq_empty_o;
    logic                   wq_overflow_o;

    modport master (
        output sb_mem_v_i, sb_mem_addr_i, sb_mem_data_i, ld_v_i, ld_addr_i,
        input  mem_sb_full_o, ld_ready_o, mem_ld_v_o, mem_ld_data_o,
               wq_empty_o, wq_overflow_o
    );

    modport slave (
        input  sb_mem_v_i, sb_mem_addr_i, sb_mem_data_i, ld_v_i, ld_addr_i,
        output mem_sb_full_o, ld_ready_o, mem_ld_v_o, mem_ld_data_o,
               wq_empty_o, wq_overflow_o
    );
endinterface

// File: rtl/data_mem_write_port.sv
// Memory-side responder for the store buffer commit port. Committed stores
// land in a small circular write queue that drains into a single-ported
// word-addressed array; loads share that array port and are forwarded from
// queued stores so a committed store is always visible to younger loads.
module data_mem_write_port #(
    parameter int WORD_SIZE_P = 16,
    parameter int WQ_ENTRY    = 4,
    parameter int MEM_WORDS   = 1024
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    data_mem_write_port_if.slave       bus_io
);
    localparam int PTR_W   = $clog2(WQ_ENTRY);
    localparam int COUNT_W = PTR_W + 1;
    localparam int IDX_W   = $clog2(MEM_WORDS);

    logic [WORD_SIZE_P-1:0] mem_q     [MEM_WORDS];
    logic [WORD_SIZE_P-1:0] wqAddr_q  [WQ_ENTRY];
    logic [WORD_SIZE_P-1:0] wqData_q  [WQ_ENTRY];

    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [COUNT_W-1:0]     count_q, count_d;
    logic                   memLdV_q, memLdV_d;
    logic [WORD_SIZE_P-1:0] memLdData_q, memLdData_d;
    logic                   overflow_q, overflow_d;

    logic                   full;
    logic                   enq;
    logic                   drain;
    logic                   ldAccept;
    logic                   qHit;
    logic [WORD_SIZE_P-1:0] qData;
    logic [PTR_W-1:0]       slot;
    logic [WORD_SIZE_P-1:0] fwdData;

    // Status flags come only from the registered occupancy.
    assign full                 = (count_q == COUNT_W'(WQ_ENTRY));
    assign bus_io.mem_sb_full_o = full;
    assign bus_io.wq_empty_o    = (count_q == '0);
    assign bus_io.mem_ld_v_o    = memLdV_q;
    assign bus_io.mem_ld_data_o = memLdData_q;
    assign bus_io.wq_overflow_o = overflow_q;

    // Single array port: a full queue forces a drain, otherwise loads win
    // and the queue drains only on otherwise idle cycles.
    assign enq      = bus_io.sb_mem_v_i && !full;
    assign ldAccept = bus_io.ld_v_i && !full;
    assign drain    = full || (!bus_io.ld_v_i && (count_q != '0));
    assign bus_io.ld_ready_o = ldAccept;

    // Youngest matching queued store: later (younger) slots overwrite earlier hits.
    always_comb begin
        qHit  = 1'b0;
        qData = '0;
        slot  = '0;
        for (int i = 0; i < WQ_ENTRY; i++) begin
            slot = head_q + PTR_W'(i);
            if ((COUNT_W'(i) < count_q) && (wqAddr_q[slot] == bus_io.ld_addr_i)) begin
                qHit  = 1'b1;
                qData = wqData_q[slot];
            end
        end
    end

    // Load data priority: same-cycle incoming store, then the queue, then the array.
    always_comb begin
        fwdData = mem_q[bus_io.ld_addr_i[IDX_W-1:0]];
        if (enq && (bus_io.sb_mem_addr_i == bus_io.ld_addr_i)) begin
            fwdData = bus_io.sb_mem_data_i;
        end else if (qHit) begin
            fwdData = qData;
        end
    end

    // Next-state for pointers, occupancy, load response and sticky overflow.
    always_comb begin
        head_d      = drain ? head_q + 1'b1 : head_q;
        tail_d      = enq   ? tail_q + 1'b1 : tail_q;
        count_d     = count_q + COUNT_W'(enq) - COUNT_W'(drain);
        memLdV_d    = ldAccept;
        memLdData_d = ldAccept ? fwdData : memLdData_q;
        overflow_d  = overflow_q || (bus_io.sb_mem_v_i && full);
    end

    // Control state with synchronous reset; pending entries are simply forgotten.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            memLdV_q    <= 1'b0;
            memLdData_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            memLdV_q    <= memLdV_d;
            memLdData_q <= memLdData_d;
            overflow_q  <= overflow_d;
        end
    end

    // Queue payload and data array have no reset; a reset cycle neither allocates nor drains.
    always_ff @(posedge clk_i) begin
        if (!reset_i && enq) begin
            wqAddr_q[tail_q] <= bus_io.sb_mem_addr_i;
            wqData_q[tail_q] <= bus_io.sb_mem_data_i;
        end
        if (!reset_i && drain) begin
            mem_q[wqAddr_q[head_q][IDX_W-1:0]] <= wqData_q[head_q];
        end
    end
endmodule

// File: doc/data_mem_write_port.md
Name: data_mem_write_port

Overview:
Memory-side responder for the store buffer's commit port. It accepts committed stores (valid/address/data, no backpressure on the valid itself) into a small write queue. It drains the queue into the word-addressed data memory array and serves load reads from the same single-ported array. Loads get store-to-load forwarding from queued, not-yet-drained stores, so committed stores are always visible to younger loads.

Parameters:
WORD_SIZE_P, 16, data and address width in bits
WQ_ENTRY, 4, write-queue depth; must be a power of 2 and at least 2
MEM_WORDS, 1024, data memory depth; must be a power of 2; index = addr[$clog2(MEM_WORDS)-1:0]

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
sb_mem_v_i  in  1  committed store valid from store buffer
sb_mem_addr_i  in  WORD_SIZE_P  store word address
sb_mem_data_i  in  WORD_SIZE_P  store data
mem_sb_full_o  out  1  write queue full; ROB must not pop a store while high
ld_v_i  in  1  load request valid
ld_addr_i  in  WORD_SIZE_P  load word address
ld_ready_o  out  1  load request accepted this cycle
mem_ld_v_o  out  1  load response valid
mem_ld_data_o  out  WORD_SIZE_P  load response data
wq_empty_o  out  1  write queue empty (fence/drain indicator)
wq_overflow_o  out  1  sticky: store arrived while full and was dropped

Behaviour:
- State: circular queue of WQ_ENTRY {addr, data}; head (drain) and tail (alloc) pointers of $clog2(WQ_ENTRY) bits that wrap naturally; count of $clog2(WQ_ENTRY)+1 bits, range 0..WQ_ENTRY.
- Reset: count=0, head=tail=0, mem_ld_v_o=0, mem_ld_data_o=0, wq_overflow_o=0. Pending queue entries are discarded. Memory array is not reset. Reset mid-operation has the same effect; the cycle after reset, mem_sb_full_o=0 and wq_empty_o=1.
- mem_sb_full_o = (count==WQ_ENTRY); wq_empty_o = (count==0). Both derive from registered count only, with no combinational path from inputs.
- Enqueue: sb_mem_v_i and !full writes the entry at tail; tail++.
  - sb_mem_v_i while full: store is dropped, queue unchanged, wq_overflow_o set until reset.
  - No same-cycle drain credit: full means reject.
- Port arbitration, one array access per cycle:
  - full: drain wins; ld_ready_o=0.
  - else ld_v_i: load wins; ld_ready_o=1, no drain.
  - else count>0: drain.
  - ld_ready_o = ld_v_i && !full.
- Drain: writes queue[head] into mem at the clock edge; head++.
  - count_next = count + enq - drain.
  - Simultaneous enqueue and drain leaves count unchanged.
  - A drain and an enqueue to the same slot cannot coincide because full blocks enqueue.
- Load (accepted in cycle N): response in cycle N+1 with mem_ld_v_o=1 for exactly one cycle. Data priority:
  1. Incoming store in cycle N (sb_mem_v_i && !full) with matching full WORD_SIZE_P address.
  2. Otherwise, the youngest valid queue entry with matching address, searching from tail-1 back to head. This includes the entry at head even if it is not draining.
  3. Otherwise, mem[index] as of cycle N.
- Address compare is on the full address; array index truncates. Aliasing beyond MEM_WORDS is the caller's problem.
- mem_ld_data_o holds its last value while mem_ld_v_o=0.
- Stores drain strictly in commit order; same-address stores leave the memory holding the youngest data.
- No mispredict input: committed stores are architectural and never flushed.

Test Plan:
- Reset, then ld_v_i addr 0x0010 (mem preloaded 0xBEEF) -> cycle N+1 mem_ld_v_o=1, data 0xBEEF; wq_empty_o=1 throughout.
- Store 0x0020←0x1234 with no loads -> queue count 1 after the edge; drained next cycle; wq_empty_o=1; later load 0x0020 returns 0x1234.
- Hold ld_v_i=1 every cycle while issuing 4 stores (0x30..0x33 ← 0xA0..0xA3) -> count reaches 4, mem_sb_full_o=1, ld_ready_o=0. One drain writes 0x30. Full then drops and ld_ready_o returns to 1.
- Stores 0x40←0x1111 then 0x40←0x2222 queued, load 0x40 held in queue -> returns 0x2222. After full drain, mem[0x40]=0x2222.
- Same cycle: store 0x50←0x7777 and load 0x50 -> next cycle data 0x7777 (incoming-store forward).
- Fill queue to 4, keep mem_sb_full_o=1 blocked by no drain opportunity? No: apply store while full and ld_v_i=0 -> store dropped, wq_overflow_o=1 sticky. Then reset mid-queue -> count=0, overflow cleared, load of a dropped address returns the old mem value.
